// File: rtl/fine_delay_if.sv
// rtl/fine_delay_if.sv - delay-load handshake and IODELAY2 control bundle
//
// Purpose: groups the delay request handshake and the IODELAY2 VARIABLE-mode
// control/status lines between the trigger side and fine_delay_ctrl.
// Ports (signals):
//   delay_val   {coarse,fine} delay request        master -> slave
//   delay_load  accept delay_val when ready        master -> slave
//   iod_busy    IODELAY2 BUSY                      master -> slave
//   delay_ready controller idle                    slave  -> master
//   iod_cal/iod_rst/iod_ce/iod_inc  IODELAY2 ctrl  slave  -> master
//   tap_now     tap tracked by the controller      slave  -> master
interface fine_delay_if #(
   parameter int COARSE_W = 8,
   parameter int TAP_W    = 8
);
   logic [COARSE_W+TAP_W-1:0] delay_val;
   logic                      delay_load;
   logic                      delay_ready;
   logic                      iod_cal;
   logic                      iod_rst;
   logic                      iod_ce;
   logic                      iod_inc;
   logic                      iod_busy;
   logic [TAP_W-1:0]          tap_now;

   modport master (
      output delay_val, delay_load, iod_busy,
      input  delay_ready, iod_cal, iod_rst, iod_ce, iod_inc, tap_now
   );

   modport slave (
      input  delay_val, delay_load, iod_busy,
      output delay_ready, iod_cal, iod_rst, iod_ce, iod_inc, tap_now
   );
endinterface

// File: rtl/fine_delay_ctrl.sv
// rtl/fine_delay_ctrl.sv - coarse start-pulse delay plus IODELAY2 fine-tap sequencer
//
// Purpose: counts a coarse delay in m_clk cycles from each start_pulse rising
// edge, and steps an IODELAY2 (VARIABLE mode) one tap per CE/BUSY handshake to
// the requested fine tap, calibrating after reset or a BUSY timeout.
// Optional feature: define FINE_DELAY_RECAL_EN to recalibrate after
// RECAL_PERIOD consecutive idle cycles.
// Ports:
//   m_clk        system clock
//   rst          synchronous reset, active-high
//   start_pulse  trigger, rising edge starts one coarse delay
//   coarse_pulse 1-cycle pulse after the coarse delay (to IODELAY2 ODATAIN)
//   pulse_miss   1-cycle flag, edge arrived during an active countdown
//   err          sticky BUSY timeout, cleared only by rst
//   bus          fine_delay_if.slave: delay_val/delay_load/delay_ready,
//                iod_cal/iod_rst/iod_ce/iod_inc/iod_busy, tap_now
module fine_delay_ctrl #(
   parameter int COARSE_W     = 8,
   parameter int TAP_W        = 8,
   parameter int MAX_TAP      = 255,
   parameter int BUSY_TMO     = 64,
   parameter int RECAL_PERIOD = 2**20
) (
   input  logic         m_clk,
   input  logic         rst,
   input  logic         start_pulse,
   output logic         coarse_pulse,
   output logic         pulse_miss,
   output logic         err,
   fine_delay_if.slave  bus
);

   localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
   localparam int               WCNT_W   = $clog2(BUSY_TMO + 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(BUSY_TMO);

   typedef enum logic [2:0] {
      S_CAL, S_CAL_W, S_RST, S_STEP_CHK, S_STEP_W, S_IDLE
   } state_t;

   state_t              state, state_nxt;
   logic [WCNT_W-1:0]   wait_cnt;
   logic                busy_seen;
   logic                timeout;
   logic                load_acc;
   logic                recal_due;
   logic [TAP_W-1:0]    tap_r, target_r;
   logic                step_up;
   logic [COARSE_W-1:0] coarse_r;
   logic                err_r;

   logic [COARSE_W-1:0] coarse_val;
   logic [TAP_W-1:0]    fine_val;

   assign coarse_val = bus.delay_val[COARSE_W+TAP_W-1:TAP_W];
   assign fine_val   = bus.delay_val[TAP_W-1:0];

   // ---------------- coarse path ----------------
   logic                start_d, start_edge, cnt_active;
   logic [COARSE_W-1:0] cnt;

   // Not reset: a level already high while rst is asserted is not a new edge.
   always_ff @(posedge m_clk) start_d <= start_pulse;

   assign start_edge = start_pulse & ~start_d;

   always_ff @(posedge m_clk) begin
      if (rst) begin
         cnt          <= '0;
         cnt_active   <= 1'b0;
         coarse_pulse <= 1'b0;
         pulse_miss   <= 1'b0;
      end else begin
         coarse_pulse <= 1'b0;
         pulse_miss   <= 1'b0;
         if (cnt_active) begin
            if (cnt == COARSE_W'(1)) begin
               coarse_pulse <= 1'b1;
               cnt_active   <= 1'b0;
            end
            cnt <= cnt - 1'b1;
            if (start_edge) pulse_miss <= 1'b1;
         end else if (start_edge) begin
            // coarse_r is the pre-load value when a load lands in the same cycle
            if (coarse_r == '0) begin
               coarse_pulse <= 1'b1;
            end else begin
               cnt        <= coarse_r;
               cnt_active <= 1'b1;
            end
         end
      end
   end

   // ---------------- optional idle recalibration ----------------
`ifdef FINE_DELAY_RECAL_EN
   localparam int RC_W = $clog2(RECAL_PERIOD + 1);
   logic [RC_W-1:0] idle_cnt;

   always_ff @(posedge m_clk) begin
      if (rst || state != S_IDLE || bus.delay_load) idle_cnt <= '0;
      else if (idle_cnt != RC_W'(RECAL_PERIOD)) idle_cnt <= idle_cnt + 1'b1;
   end

   assign recal_due = (idle_cnt == RC_W'(RECAL_PERIOD - 1));
`else
   // Recalibration period has no meaning in this build.
   logic unused_recal;
   assign unused_recal = (RECAL_PERIOD == 0);
   assign recal_due    = 1'b0;
`endif

   // ---------------- fine FSM: state register ----------------
   always_ff @(posedge m_clk) begin
      if (rst) begin
         state     <= S_CAL;
         wait_cnt  <= '0;
         busy_seen <= 1'b0;
      end else begin
         state <= state_nxt;
         // Cycles spent in the current state; only meaningful in the wait states.
         if (state_nxt != state)      wait_cnt <= '0;
         else if (wait_cnt != WCNT_MAX) wait_cnt <= wait_cnt + 1'b1;
         busy_seen <= (state == S_CAL_W) && (state_nxt == S_CAL_W) &&
                      (busy_seen || bus.iod_busy);
      end
   end

   // ---------------- fine FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      load_acc  = 1'b0;
      case (state)
         S_CAL:      state_nxt = S_CAL_W;
         S_CAL_W: begin
            if (busy_seen && !bus.iod_busy) state_nxt = S_RST;
            else if (wait_cnt == WCNT_MAX)  timeout   = 1'b1;
         end
         S_RST:      state_nxt = S_STEP_CHK;
         S_STEP_CHK: state_nxt = (tap_r == target_r) ? S_IDLE : S_STEP_W;
         S_STEP_W: begin
            if (!bus.iod_busy)             state_nxt = S_STEP_CHK;
            else if (wait_cnt == WCNT_MAX) timeout   = 1'b1;
         end
         S_IDLE: begin
            if (bus.delay_load) begin
               load_acc  = 1'b1;
               state_nxt = S_STEP_CHK;
            end else if (recal_due) begin
               state_nxt = S_CAL;
            end
         end
         default:    state_nxt = S_CAL;
      endcase
      if (timeout) state_nxt = S_CAL;
   end

   // ---------------- fine datapath ----------------
   always_ff @(posedge m_clk) begin
      if (rst) begin
         tap_r    <= '0;
         target_r <= '0;
         coarse_r <= '0;
         step_up  <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         if (timeout) err_r <= 1'b1;
         if (load_acc) begin
            coarse_r <= coarse_val;
            target_r <= (fine_val > TAP_MAX) ? TAP_MAX : fine_val;
         end
         if (state == S_RST) tap_r <= '0;
         if (state == S_STEP_CHK) step_up <= (target_r > tap_r);
         // Tap moves only toward a target within 0..MAX_TAP, so it cannot wrap.
         if (state == S_STEP_W && state_nxt == S_STEP_CHK)
            tap_r <= step_up ? tap_r + 1'b1 : tap_r - 1'b1;
      end
   end

   // ---------------- fine FSM: outputs ----------------
   // Gated by rst so every output reads 0 while reset is held.
   always_comb begin
      bus.delay_ready = 1'b0;
      bus.iod_cal     = 1'b0;
      bus.iod_rst     = 1'b0;
      bus.iod_ce      = 1'b0;
      bus.iod_inc     = 1'b0;
      if (!rst) begin
         case (state)
            S_CAL:      bus.iod_cal = 1'b1;
            S_RST:      bus.iod_rst = 1'b1;
            S_STEP_CHK: begin
               if (tap_r != target_r) begin
                  bus.iod_ce  = 1'b1;
                  bus.iod_inc = (target_r > tap_r);
               end
            end
            S_IDLE:     bus.delay_ready = 1'b1;
            default:    ;
         endcase
      end
   end

   assign bus.tap_now = tap_r;
   assign err         = err_r;

endmodule

// File: tb/tb_fine_delay_ctrl.sv
// tb/tb_fine_delay_ctrl.sv - randomized self-checking bench for fine_delay_ctrl
module tb_fine_delay_ctrl;
   localparam int CW   = 8;
   localparam int TW   = 9;
   localparam int MAXT = 255;
   localparam int TMO  = 64;

   logic m_clk = 1'b0;
   logic rst, start_pulse;
   logic coarse_pulse, pulse_miss, err;

   fine_delay_if #(.COARSE_W(CW), .TAP_W(TW)) bus ();

   fine_delay_ctrl #(
      .COARSE_W(CW), .TAP_W(TW), .MAX_TAP(MAXT), .BUSY_TMO(TMO), .RECAL_PERIOD(1 << 20)
   ) dut (
      .m_clk(m_clk), .rst(rst), .start_pulse(start_pulse),
      .coarse_pulse(coarse_pulse), .pulse_miss(pulse_miss), .err(err),
      .bus(bus)
   );

   always #5 m_clk = ~m_clk;

   int cyc = 0;
   always @(posedge m_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: expected settled tap, coarse value, countdown window.
   int m_tap, m_coarse, m_active_end;
   bit exp_pulse[int];
   bit exp_miss[int];

   // IODELAY2 BUSY model and output monitor.
   int busy_lat  = 2;
   int busy_left = 0;
   bit hold_busy = 0;
   int n_cal, n_rst, n_up, n_dn;

   always @(negedge m_clk) begin
      if (bus.iod_cal || bus.iod_ce) busy_left = busy_lat;
      else if (busy_left > 0)        busy_left--;
      bus.iod_busy = hold_busy || (busy_left > 0);
      if (bus.iod_cal) n_cal++;
      if (bus.iod_rst) n_rst++;
      if (bus.iod_ce) begin
         if (bus.iod_inc) n_up++;
         else             n_dn++;
      end
      if (coarse_pulse || exp_pulse.exists(cyc))
         check("coarse_pulse", coarse_pulse, exp_pulse.exists(cyc));
      if (pulse_miss || exp_miss.exists(cyc))
         check("pulse_miss", pulse_miss, exp_miss.exists(cyc));
      if (bus.tap_now > MAXT) check("tap_range", bus.tap_now, MAXT);
   end

   task automatic tick();
      @(posedge m_clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_pulse.delete();
      exp_miss.delete();
      m_active_end = -1000;
      tick();
      check("rst_outputs", {coarse_pulse, pulse_miss, err, bus.delay_ready,
                            bus.iod_cal, bus.iod_rst, bus.iod_ce, bus.iod_inc}, 0);
      check("rst_tap", bus.tap_now, 0);
      tick();
      n_cal = 0;
      n_rst = 0;
      rst = 1'b0;
      m_tap = 0;
      m_coarse = 0;
   endtask

   task automatic wait_ready(input string tag);
      int i;
      for (i = 0; i < 3000; i++) begin
         if (bus.delay_ready) break;
         tick();
      end
      if (i == 3000) check(tag, 0, 1);
   endtask

   task automatic model_edge();
      int k = cyc;
      if (k <= m_active_end) exp_miss[k + 1] = 1'b1;
      else begin
         exp_pulse[k + 1 + m_coarse] = 1'b1;
         m_active_end = k + m_coarse;
      end
   endtask

   task automatic fire_edge();
      model_edge();
      start_pulse = 1'b1;
      tick();
      start_pulse = 1'b0;
      tick();
   endtask

   task automatic do_load(input int c, input int f, input bit with_edge, input bit ign);
      int prev = m_tap;
      check("load_ready", bus.delay_ready, 1);
      bus.delay_val  = {CW'(c), TW'(f)};
      bus.delay_load = 1'b1;
      if (with_edge) begin
         model_edge();
         start_pulse = 1'b1;
      end
      n_up = 0;
      n_dn = 0;
      tick();
      bus.delay_load = 1'b0;
      start_pulse    = 1'b0;
      m_coarse = c;
      m_tap    = (f > MAXT) ? MAXT : f;
      check("ready_drop", bus.delay_ready, 0);
      if (ign) begin
         bus.delay_val  = {CW'($urandom_range(0, 20)), TW'($urandom_range(0, 300))};
         bus.delay_load = 1'b1;
         tick();
         bus.delay_load = 1'b0;
      end
      wait_ready("load_ready_timeout");
      check("tap_now", bus.tap_now, m_tap);
      check("ce_up", n_up, (m_tap > prev) ? m_tap - prev : 0);
      check("ce_dn", n_dn, (prev > m_tap) ? prev - m_tap : 0);
   endtask

   initial begin
      rst = 1'b1;
      start_pulse = 1'b0;
      bus.delay_val = '0;
      bus.delay_load = 1'b0;
      bus.iod_busy = 1'b0;

      // T1 reset and calibration
      do_reset();
      wait_ready("t1_ready_timeout");
      check("t1_cal_pulses", n_cal, 1);
      check("t1_rst_pulses", n_rst, 1);
      check("t1_tap", bus.tap_now, 0);
      check("t1_err", err, 0);

      // T2 coarse 5 vs coarse 0
      do_load(5, 3, 0, 0);
      fire_edge();
      repeat (10) tick();
      do_load(0, 3, 0, 0);
      fire_edge();
      repeat (4) tick();

      // T3 down-stepping and clamp
      do_load(5, 10, 0, 0);
      do_load(5, 7, 0, 0);
      do_load(5, 300, 0, 0);

      // T4 edge during countdown, then edge coincident with load, then ignored load
      do_load(10, 255, 0, 0);
      fire_edge();
      fire_edge();
      repeat (15) tick();
      do_load(2, 250, 1, 0);
      repeat (15) tick();
      do_load(3, 0, 0, 1);
      repeat (5) tick();

      // Randomized loads, latencies and edges
      for (int it = 0; it < 8; it++) begin
         busy_lat = $urandom_range(1, 4);
         do_load($urandom_range(0, 12), $urandom_range(0, 320),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            fire_edge();
            repeat ($urandom_range(0, 12)) tick();
         end
      end
      repeat (20) tick();

      // T5 BUSY stuck high during stepping
      busy_lat = 2;
      begin
         int t = (m_tap == 6) ? 7 : 6;
         hold_busy = 1'b1;
         n_cal = 0;
         bus.delay_val  = {CW'(4), TW'(t)};
         bus.delay_load = 1'b1;
         tick();
         bus.delay_load = 1'b0;
         m_coarse = 4;
         m_tap = t;
         repeat (30) tick();
         check("t5_err_early", err, 0);
         repeat (45) tick();
         check("t5_err_set", err, 1);
         hold_busy = 1'b0;
         n_up = 0;
         wait_ready("t5_ready_timeout");
         check("t5_recal", n_cal, 1);
         check("t5_tap", bus.tap_now, t);
         check("t5_restep", n_up, t);
         repeat (50) tick();
         check("t5_err_sticky", err, 1);
      end
      do_reset();
      check("t5_err_cleared", err, 0);
      wait_ready("t5b_ready_timeout");

      // T6 reset mid-stepping with a countdown in flight
      busy_lat = 4;
      begin
         int i;
         bus.delay_val  = {CW'(40), TW'(9)};
         bus.delay_load = 1'b1;
         tick();
         bus.delay_load = 1'b0;
         m_coarse = 40;
         m_tap = 9;
         fire_edge();
         for (i = 0; i < 200; i++) begin
            if (bus.tap_now == 4) break;
            tick();
         end
         if (i == 200) check("t6_tap4_timeout", 0, 1);
         do_reset();
         wait_ready("t6_ready_timeout");
         check("t6_cal_pulses", n_cal, 1);
         check("t6_tap", bus.tap_now, 0);
         repeat (60) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
